// File: rtl/aq32_esp_pkg.sv
// Shared ESP command constants, error codes and boot-loader state encoding
// for the aq32 hardware boot path.
package aq32_esp_pkg;

  localparam logic [7:0] CMD_RESET    = 8'h01;
  localparam logic [7:0] CMD_OPEN     = 8'h10;
  localparam logic [7:0] CMD_READ     = 8'h12;
  localparam logic [7:0] CMD_CLOSEALL = 8'h1F;
  localparam logic [8:0] SOC_MARK     = 9'h100;
  localparam logic [7:0] ERR_LEN      = 8'hFD;
  localparam logic [7:0] ERR_RANGE    = 8'hFE;

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_CLALL, S_CLALL_RES, S_OPEN_CMD, S_OPEN_PATH, S_OPEN_RES,
    S_RD_CMD, S_RD_RES, S_RD_LEN_LO, S_RD_LEN_HI, S_RD_DATA, S_FIN, S_FIN_RES,
    S_DONE, S_ERROR
  } state_e;

  // Two-beat command: start-of-command marker, then the opcode byte.
  function automatic logic [8:0] cmd_beat(input logic [2:0] idx, input logic [7:0] cmd);
    if (idx == 3'd0) return SOC_MARK;
    else return {1'b0, cmd};
  endfunction

  function automatic logic is_rx_state(input state_e s);
    case (s)
      S_CLALL_RES, S_OPEN_RES, S_RD_RES, S_RD_LEN_LO,
      S_RD_LEN_HI, S_RD_DATA, S_FIN_RES: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_result_state(input state_e s);
    case (s)
      S_CLALL_RES, S_OPEN_RES, S_RD_RES, S_FIN_RES: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/esp_boot_loader_path_rom.sv
// Registered byte ROM holding the NUL-terminated boot file path; data
// appears one cycle after the address.
module boot_path_rom (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] addr,
  output logic [7:0] data
);

  localparam int PATH_LEN = 22;
  localparam logic [8*PATH_LEN-1:0] BOOT_PATH = {"/cores/aq32/boot.aq32", 8'h00};

  // Byte 0 of the path is the most significant byte of BOOT_PATH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data <= 8'h00;
    else if (addr < 5'(PATH_LEN)) data <= BOOT_PATH[8*(PATH_LEN-1-int'(addr)) +: 8];
    else data <= 8'h00;
  end

endmodule

// File: rtl/esp_boot_loader.sv
// Boot sequencer: holds the aq32 CPU in reset, drives the ESP command stream
// to copy the boot image into RAM, then releases the CPU.
module esp_boot_loader
  import aq32_esp_pkg::*;
#(
  parameter int              ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] LOAD_BASE = 20'h80000,
  parameter logic [15:0]     CHUNK     = 16'h8000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [8:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wrdata,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        error_code,
  output logic [ADDR_W-1:0] bytes_loaded,
  output logic              cpu_reset_hold
);

  localparam logic [ADDR_W+1:0] ADDR_SPACE = {2'b01, {ADDR_W{1'b0}}};

  state_e              state_r, send_nxt_s;
  logic [2:0]          idx_r;
  logic [4:0]          path_idx_r, rom_addr_s;
  logic [7:0]          path_byte_s, fd_r, len_lo_r, fail_code_s;
  logic [15:0]         remain_r, len_s;
  logic [8:0]          tx_data_r, beat_s;
  logic                tx_valid_r, mem_wr_r, busy_r, done_r, error_r, cpu_hold_r;
  logic [7:0]          mem_wrdata_r, error_code_r;
  logic [ADDR_W-1:0]   mem_addr_r, bytes_loaded_r;
  logic [ADDR_W+1:0]   end_s;
  logic                last_s, rx_ready_s, rx_fire_s, fail_s;

  assign rx_ready_s = is_rx_state(state_r);
  assign rx_fire_s  = rx_valid & rx_ready_s;

  // Prefetch: advance the ROM address in the cycle a path byte is accepted.
  always_comb begin
    if (state_r == S_OPEN_PATH && tx_valid_r && tx_ready) rom_addr_s = path_idx_r + 5'd1;
    else rom_addr_s = path_idx_r;
  end

  boot_path_rom u_path_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (rom_addr_s),
    .data  (path_byte_s)
  );

  // Next outgoing beat, whether it ends the current command, and where to go after.
  always_comb begin
    beat_s     = SOC_MARK;
    last_s     = 1'b0;
    send_nxt_s = S_IDLE;
    case (state_r)
      S_RST:      begin beat_s = cmd_beat(idx_r, CMD_RESET);    last_s = (idx_r == 3'd1); send_nxt_s = S_CLALL;     end
      S_CLALL:    begin beat_s = cmd_beat(idx_r, CMD_CLOSEALL); last_s = (idx_r == 3'd1); send_nxt_s = S_CLALL_RES; end
      S_OPEN_CMD: begin beat_s = cmd_beat(idx_r, CMD_OPEN);     last_s = (idx_r == 3'd1); send_nxt_s = S_OPEN_PATH; end
      S_OPEN_PATH: begin
        beat_s     = {1'b0, path_byte_s};
        last_s     = (tx_data_r[7:0] == 8'h00);
        send_nxt_s = S_OPEN_RES;
      end
      S_RD_CMD: begin
        case (idx_r)
          3'd0, 3'd1: beat_s = cmd_beat(idx_r, CMD_READ);
          3'd2:       beat_s = {1'b0, fd_r};
          3'd3:       beat_s = {1'b0, CHUNK[7:0]};
          default:    beat_s = {1'b0, CHUNK[15:8]};
        endcase
        last_s     = (idx_r == 3'd4);
        send_nxt_s = S_RD_RES;
      end
      S_FIN:      begin beat_s = cmd_beat(idx_r, CMD_CLOSEALL); last_s = (idx_r == 3'd1); send_nxt_s = S_FIN_RES;   end
      default:    begin beat_s = SOC_MARK; last_s = 1'b0; send_nxt_s = S_IDLE; end
    endcase
  end

  // Abort conditions in priority order: bad result byte, oversize chunk, RAM overrun.
  always_comb begin
    len_s = {rx_data, len_lo_r};
    end_s = (ADDR_W+2)'(LOAD_BASE) + (ADDR_W+2)'(bytes_loaded_r) + (ADDR_W+2)'(len_s);
    if (rx_fire_s && is_result_state(state_r) && rx_data[7]) begin
      fail_s = 1'b1; fail_code_s = rx_data;
    end else if (rx_fire_s && state_r == S_RD_LEN_HI && len_s > CHUNK) begin
      fail_s = 1'b1; fail_code_s = ERR_LEN;
    end else if (rx_fire_s && state_r == S_RD_LEN_HI && end_s > ADDR_SPACE) begin
      fail_s = 1'b1; fail_code_s = ERR_RANGE;
    end else begin
      fail_s = 1'b0; fail_code_s = 8'h00;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE; idx_r <= 3'd0; path_idx_r <= 5'd0;
      fd_r <= 8'h00; len_lo_r <= 8'h00; remain_r <= 16'h0000;
      tx_data_r <= 9'h000; tx_valid_r <= 1'b0;
      mem_wr_r <= 1'b0; mem_addr_r <= '0; mem_wrdata_r <= 8'h00;
      busy_r <= 1'b0; done_r <= 1'b0; error_r <= 1'b0; error_code_r <= 8'h00;
      bytes_loaded_r <= '0; cpu_hold_r <= 1'b1;
    end else begin
      mem_wr_r <= 1'b0;
      if (fail_s) begin
        state_r <= S_ERROR; error_r <= 1'b1; error_code_r <= fail_code_s; busy_r <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              state_r <= S_RST; idx_r <= 3'd0; path_idx_r <= 5'd0; tx_valid_r <= 1'b0;
              done_r <= 1'b0; error_r <= 1'b0; error_code_r <= 8'h00;
              bytes_loaded_r <= '0; busy_r <= 1'b1; cpu_hold_r <= 1'b1;
            end
          end
          S_RST, S_CLALL, S_OPEN_CMD, S_OPEN_PATH, S_RD_CMD, S_FIN: begin
            if (!tx_valid_r) begin
              tx_valid_r <= 1'b1; tx_data_r <= beat_s;
            end else if (tx_ready) begin
              tx_valid_r <= 1'b0;
              if (state_r == S_OPEN_PATH) path_idx_r <= path_idx_r + 5'd1;
              if (last_s) begin state_r <= send_nxt_s; idx_r <= 3'd0; end
              else idx_r <= idx_r + 3'd1;
            end
          end
          S_CLALL_RES: if (rx_fire_s) state_r <= S_OPEN_CMD;
          S_OPEN_RES:  if (rx_fire_s) begin fd_r <= rx_data; state_r <= S_RD_CMD; end
          S_RD_RES:    if (rx_fire_s) state_r <= S_RD_LEN_LO;
          S_RD_LEN_LO: if (rx_fire_s) begin len_lo_r <= rx_data; state_r <= S_RD_LEN_HI; end
          S_RD_LEN_HI: begin
            if (rx_fire_s) begin
              if (len_s == 16'h0000) state_r <= S_FIN;
              else begin remain_r <= len_s; state_r <= S_RD_DATA; end
            end
          end
          S_RD_DATA: begin
            if (rx_fire_s) begin
              mem_wr_r <= 1'b1; mem_addr_r <= LOAD_BASE + bytes_loaded_r; mem_wrdata_r <= rx_data;
              bytes_loaded_r <= bytes_loaded_r + ADDR_W'(1);
              remain_r <= remain_r - 16'd1;
              if (remain_r == 16'd1) state_r <= S_RD_CMD;
            end
          end
          S_FIN_RES: begin
            if (rx_fire_s) begin
              state_r <= S_DONE; done_r <= 1'b1; busy_r <= 1'b0; cpu_hold_r <= 1'b0;
            end
          end
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_data        = tx_data_r;
  assign tx_valid       = tx_valid_r;
  assign rx_ready       = rx_ready_s;
  assign mem_addr       = mem_addr_r;
  assign mem_wrdata     = mem_wrdata_r;
  assign mem_wr         = mem_wr_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;
  assign error_code     = error_code_r;
  assign bytes_loaded   = bytes_loaded_r;
  assign cpu_reset_hold = cpu_hold_r;

endmodule

// File: tb/tb_esp_boot_loader.sv
// Bench for esp_boot_loader: an ESP byte-stream model plus a reference of the
// expected TX stream and RAM writes, checked every cycle.
module tb_esp_boot_loader;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [19:0] mem_addr, bytes_loaded;
  logic [7:0]  mem_wrdata, error_code;
  logic        mem_wr, busy, done, error, cpu_reset_hold;

  esp_boot_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wr(mem_wr),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .bytes_loaded(bytes_loaded), .cpu_reset_hold(cpu_reset_hold)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int scen = 0, mon_scen = 0, drv_scen = 0;
  int tx_idx = 0, wr_seen = 0, esp_idx = 0;
  bit mon_en = 1'b0, bp_mode = 1'b0, rx_take = 1'b0, stall_prev = 1'b0;
  logic [8:0]  stall_data;
  logic [19:0] last_addr = 20'h0;
  logic [7:0]  esp_q[$];
  logic [8:0]  exp_tx[$];
  logic [7:0]  exp_wr[$];
  int          lens_q[$];
  logic        exp_done, exp_err;
  logic [7:0]  exp_code;
  int          exp_bytes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ESP side: presents queued response bytes (with optional gaps) and random tx_ready.
  always @(posedge clk) begin
    #1;
    if (scen != drv_scen) begin drv_scen = scen; esp_idx = 0; rx_valid = 1'b0; end
    else if (rx_take) begin esp_idx++; rx_valid = 1'b0; end
    tx_ready = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (!rx_valid && esp_idx < esp_q.size() && (!bp_mode || $urandom_range(0, 3) != 0)) begin
      rx_valid = 1'b1;
      rx_data  = esp_q[esp_idx];
    end
  end

  // Compare process: every beat and write against the reference, every cycle.
  always @(negedge clk) begin
    if (scen != mon_scen) begin mon_scen = scen; tx_idx = 0; wr_seen = 0; stall_prev = 1'b0; end
    rx_take = mon_en && rx_valid && rx_ready;
    if (mon_en) begin
      check("hold_vs_done", {31'd0, cpu_reset_hold}, {31'd0, !done});
      check("busy_exclusive", {31'd0, busy && (done || error)}, 32'd0);
      if (stall_prev) begin
        check("tx_stall_valid", {31'd0, tx_valid}, 32'd1);
        check("tx_stall_data", {23'd0, tx_data}, {23'd0, stall_data});
      end
      if (tx_valid && tx_ready) begin
        if (tx_idx < exp_tx.size()) check("tx_beat", {23'd0, tx_data}, {23'd0, exp_tx[tx_idx]});
        else begin checks++; failures++; $display("FAIL tx_extra: got %0h expected no beat", tx_data); end
        tx_idx++;
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (mem_wr) begin
        if (wr_seen < exp_wr.size()) begin
          check("wr_addr", {12'd0, mem_addr}, 32'h80000 + wr_seen);
          check("wr_data", {24'd0, mem_wrdata}, {24'd0, exp_wr[wr_seen]});
          check("wr_count", {12'd0, bytes_loaded}, wr_seen + 1);
        end else begin checks++; failures++; $display("FAIL wr_extra: got addr %0h expected no write", mem_addr); end
        last_addr = mem_addr;
        wr_seen++;
      end
    end
  end

  task automatic push_cmd(input logic [7:0] c);
    exp_tx.push_back(9'h100);
    exp_tx.push_back({1'b0, c});
  endtask

  // Reference: what the ESP says and what must appear on TX and RAM.
  task automatic build(input logic [7:0] open_res, input bit happy_pat);
    string path;
    int k;
    logic [15:0] l;
    logic [31:0] kv;
    path = "/cores/aq32/boot.aq32";
    esp_q.delete(); exp_tx.delete(); exp_wr.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_code = 8'h00; exp_bytes = 0; k = 0;
    push_cmd(8'h01);
    push_cmd(8'h1F); esp_q.push_back(8'h00);
    push_cmd(8'h10);
    for (int i = 0; i < path.len(); i++) exp_tx.push_back({1'b0, path[i]});
    exp_tx.push_back(9'h000);
    esp_q.push_back(open_res);
    if (open_res[7]) begin exp_err = 1'b1; exp_code = open_res; return; end
    foreach (lens_q[j]) begin
      l = 16'(lens_q[j]);
      push_cmd(8'h12);
      exp_tx.push_back({1'b0, open_res}); exp_tx.push_back(9'h000); exp_tx.push_back(9'h080);
      esp_q.push_back(8'h00); esp_q.push_back(l[7:0]); esp_q.push_back(l[15:8]);
      if (lens_q[j] > 32768) begin exp_err = 1'b1; exp_code = 8'hFD; return; end
      if (32'h80000 + exp_bytes + lens_q[j] > 32'h100000) begin exp_err = 1'b1; exp_code = 8'hFE; return; end
      if (lens_q[j] == 0) break;
      for (int b = 0; b < lens_q[j]; b++) begin
        kv = k;
        if (happy_pat) esp_q.push_back(8'hAA + 8'(8'h11 * kv[7:0]));
        else esp_q.push_back(kv[7:0] ^ kv[15:8]);
        exp_wr.push_back(esp_q[esp_q.size()-1]);
        k++; exp_bytes++;
      end
    end
    push_cmd(8'h1F); esp_q.push_back(8'h00);
    exp_done = 1'b1;
  endtask

  task automatic launch();
    @(negedge clk); #2;
    scen++; mon_en = 1'b1; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic run(input string name);
    int n;
    n = 0;
    launch();
    while (!(done || error) && n < 40000) begin @(negedge clk); #1; n++; end
    if (n >= 40000) begin checks++; failures++; $display("FAIL %s_timeout: got no done/error expected completion", name); end
    repeat (20) @(negedge clk);
    #1;
    check({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
    check({name, "_error"}, {31'd0, error}, {31'd0, exp_err});
    check({name, "_code"}, {24'd0, error_code}, {24'd0, exp_code});
    check({name, "_bytes"}, {12'd0, bytes_loaded}, exp_bytes);
    check({name, "_hold"}, {31'd0, cpu_reset_hold}, {31'd0, !exp_done});
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_tx_count"}, tx_idx, exp_tx.size());
    check({name, "_wr_count"}, wr_seen, exp_wr.size());
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({name, "_tx_data"}, {23'd0, tx_data}, 32'd0);
    check({name, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({name, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
    check({name, "_mem_addr"}, {12'd0, mem_addr}, 32'd0);
    check({name, "_mem_wrdata"}, {24'd0, mem_wrdata}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_error"}, {31'd0, error}, 32'd0);
    check({name, "_error_code"}, {24'd0, error_code}, 32'd0);
    check({name, "_bytes_loaded"}, {12'd0, bytes_loaded}, 32'd0);
    check({name, "_cpu_hold"}, {31'd0, cpu_reset_hold}, 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_vals("por");
    #1 reset = 1'b0;

    // Happy path, with literal pins on the reference itself.
    lens_q.delete(); lens_q.push_back(5); lens_q.push_back(0);
    build(8'h03, 1'b1);
    check("model_tx_len", exp_tx.size(), 32'd40);
    check("model_path_first", {23'd0, exp_tx[6]}, 32'h02F);
    check("model_rd_chunk_hi", {23'd0, exp_tx[32]}, 32'h080);
    check("model_last_byte", {24'd0, exp_wr[4]}, 32'hEE);
    run("happy");
    check("happy_bytes_lit", {12'd0, bytes_loaded}, 32'd5);
    check("happy_last_addr", {12'd0, last_addr}, 32'h80004);

    // Open result with bit7 set.
    lens_q.delete();
    build(8'hF8, 1'b0);
    run("open_fail");
    check("open_fail_code_lit", {24'd0, error_code}, 32'hF8);

    // Full chunk, short chunk, end of file.
    lens_q.delete(); lens_q.push_back(32768); lens_q.push_back(3); lens_q.push_back(0);
    build(8'h03, 1'b0);
    run("multi");
    check("multi_writes_lit", wr_seen, 32'd32771);
    check("multi_last_addr", {12'd0, last_addr}, 32'h88002);

    // Happy path under TX and RX backpressure.
    bp_mode = 1'b1;
    lens_q.delete(); lens_q.push_back(5); lens_q.push_back(0);
    build(8'h03, 1'b1);
    run("backpressure");
    bp_mode = 1'b0;

    // Length one past the chunk size.
    lens_q.delete(); lens_q.push_back(32769);
    build(8'h03, 1'b0);
    run("bad_len");
    check("bad_len_code_lit", {24'd0, error_code}, 32'hFD);

    // Reset after three data bytes, then a clean rerun.
    lens_q.delete(); lens_q.push_back(5); lens_q.push_back(0);
    build(8'h03, 1'b1);
    launch();
    n = 0;
    while (wr_seen < 3 && n < 2000) begin @(negedge clk); #1; n++; end
    if (n >= 2000) begin checks++; failures++; $display("FAIL midreset_wait: got %0d writes expected 3", wr_seen); end
    reset = 1'b1;
    #1 check_reset_vals("midreset");
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    build(8'h03, 1'b1);
    run("rerun");
    check("rerun_last_addr", {12'd0, last_addr}, 32'h80004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/esp_boot_loader.md
Name: esp_boot_loader

Overview:
- Hardware boot sequencer for the aq32 core.
- Holds the CPU in reset, then drives the ESP command byte stream itself: reset, close-all, open the boot file, chunked reads into RAM at the load base, close-all.
- Releases the CPU once the image is in RAM, so software never has to poll the ESP UART to boot.
- Sits between the ESP UART byte FIFOs and a RAM write port.

Parameters:
LOAD_BASE, 20'h80000, RAM byte address of the first loaded byte
CHUNK, 16'h8000, byte count requested per read command
ADDR_W, 20, RAM byte-address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins sequence from IDLE/DONE/ERROR
tx_data  out  9  byte to ESP; bit8=1 marks start-of-command
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts a beat
rx_data  in  8  byte from ESP
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader consumes a beat
mem_addr  out  ADDR_W  RAM write byte address
mem_wrdata  out  8  RAM write data
mem_wr  out  1  one-cycle write strobe; always accepted
busy  out  1  sequence in progress
done  out  1  image loaded; held until start/reset
error  out  1  sequence aborted; held until start/reset
error_code  out  8  failing result byte, or 8'hFD/8'hFE
bytes_loaded  out  ADDR_W  bytes written so far
cpu_reset_hold  out  1  hold aq32 CPU in reset

Behaviour:
- Reset values: all outputs 0, except cpu_reset_hold=1; FSM enters IDLE.
- Reset asserted mid-operation aborts immediately; no further tx/mem beats occur.
- Handshakes:
  - tx beat transfers when tx_valid&tx_ready; tx_data stays stable while tx_valid&!tx_ready.
  - rx beat transfers when rx_valid&rx_ready; rx_ready is high only in receive states.
- Send-command(c): beat 9'h100, then {1'b0,c}.
- FSM sequence:
  - IDLE: on start, clear done/error/bytes_loaded, set busy.
  - RST: send-command 01.
  - CLALL: send-command 1F, receive 1 result byte.
  - OPEN: send-command 10, then path bytes from boot_path_rom up to and including NUL; receive result byte (fd).
  - RD_CMD: send-command 12, fd, CHUNK[7:0], CHUNK[15:8].
  - RD_RES: receive result byte.
  - RD_LEN: receive len_lo, then len_hi.
  - If len==0: go to FIN.
  - RD_DATA: receive len bytes. Each accepted byte produces mem_wr one cycle later, with mem_addr=LOAD_BASE+bytes_loaded and mem_wrdata=byte; bytes_loaded increments with mem_wr. Return to RD_CMD when len bytes are done.
  - FIN: send-command 1F, receive result; then DONE.
  - DONE: done=1, busy=0, cpu_reset_hold=0.
  - ERROR: error=1, busy=0, cpu_reset_hold stays 1.
- Error rules, checked in priority order:
  - Any result byte (close-all, open, read, close) with bit7=1 goes to ERROR with error_code = that byte.
  - len>CHUNK goes to ERROR, code 8'hFD.
  - LOAD_BASE+bytes_loaded+len > 2^ADDR_W goes to ERROR, code 8'hFE, before any byte of that chunk is written.
- start while busy is ignored.
- start in DONE re-asserts cpu_reset_hold and reruns the sequence.
- The byte after the final data byte of a chunk may arrive the next cycle; no bubble is required.

Decomposition:
- Shared package aq32_esp_pkg:
  - ESP command constants: CMD_RESET=8'h01, CMD_OPEN=8'h10, CMD_READ=8'h12, CMD_CLOSEALL=8'h1F.
  - Start-of-command marker 9'h100.
  - Error codes 8'hFD/8'hFE.
  - FSM state enum.
- Sub-module boot_path_rom: registered 1-cycle-latency byte ROM holding "/cores/aq32/boot.aq32\0", indexed by a 5-bit counter; the loader prefetches one byte ahead.

Test Plan:
1. Happy path:
   - Stimulus: ESP model returns 00 (close-all), 03 (fd), read result 00, len 0005, bytes AA BB CC DD EE, then read result 00, len 0000, close result 00.
   - Response: exact tx stream 100,01,100,1F,100,10,path+00,100,12,03,00,80,...,100,1F.
   - Writes AA..EE land at 0x80000..0x80004.
   - Final state: done=1, bytes_loaded=5, cpu_reset_hold=0.
2. Open fails: open result F8 -> error=1, error_code=F8, no mem_wr, cpu_reset_hold=1, no tx beats after path NUL.
3. Multi-chunk: lens 8000, 0003, 0000 -> 32771 writes, last at 0x88002, done=1.
4. Backpressure: random tx_ready and rx_valid gaps over scenario 1 -> identical tx stream and RAM contents; tx_data stable during stalls.
5. Bad length: len 8001 -> error_code=FD, zero writes.
6. Reset mid-stream: reset asserted after 3 data bytes -> all outputs at reset values that cycle; a subsequent start reruns scenario 1 cleanly.
